l2_writeback_buffer: RTL and testbench

L2_WRITEBACK_BUFFER -- requirements
Module: l2_writeback_buffer

---
 rtl/l2_writeback_buffer_pkg.sv | 22 ++
 rtl/l2_writeback_buffer.sv | 121 ++++++++++++
 tb/tb_l2_writeback_buffer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/l2_writeback_buffer_pkg.sv
// Shared definitions for the L2 write-back buffer: opcodes, entry layout, drain states.
package l2_writeback_buffer_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef struct packed {
        logic        valid;
        logic [29:0] addr;
        logic [31:0] data;
    } wb_entry_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DRAIN = 1'b1
    } drain_state_t;

    function automatic logic is_load(input logic [6:0] op);
        return op == OPC_LOAD;
    endfunction

endpackage

// File: rtl/l2_writeback_buffer.sv
// Circular write-back buffer between L2 evictions and data memory, with in-place
// coalescing, youngest-match load forwarding and a one-write-at-a-time drain FSM.
module l2_writeback_buffer
    import l2_writeback_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_valid_in,
    input  logic [29:0] wb_address_in,
    input  logic [31:0] wb_data_in,
    output logic        wb_ready_out,
    input  logic [6:0]  rd_opcode_in,
    input  logic [29:0] rd_address_in,
    output logic        fwd_hit_out,
    output logic [31:0] fwd_data_out,
    output logic        dmem_we_out,
    output logic [29:0] dmem_address_out,
    output logic [31:0] dmem_data_out,
    input  logic        dmem_ack_in,
    output logic        empty_out,
    output logic        overflow_out
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    wb_entry_t     r_entries [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    drain_state_t  r_state;
    logic          r_overflow;

    logic          w_coal;
    logic [PW-1:0] w_coal_idx;
    logic          w_push;
    logic          w_pop;
    logic          w_drop;
    logic          w_fwd_hit;
    logic [31:0]   w_fwd_data;
    logic          w_draining;

    assign w_draining = (r_state == ST_DRAIN);

    // Walk entries oldest to youngest so the last match seen is the youngest.
    always_comb begin
        w_coal     = 1'b0;
        w_coal_idx = '0;
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < r_count && r_entries[r_head + PW'(k)].valid) begin
                if (r_entries[r_head + PW'(k)].addr == wb_address_in
                        && !(w_draining && k == 0)) begin
                    w_coal     = wb_valid_in;
                    w_coal_idx = r_head + PW'(k);
                end
                if (is_load(rd_opcode_in)
                        && r_entries[r_head + PW'(k)].addr == rd_address_in) begin
                    w_fwd_hit  = 1'b1;
                    w_fwd_data = r_entries[r_head + PW'(k)].data;
                end
            end
        end
    end

    assign wb_ready_out = (r_count < FULL_CNT);
    assign w_push       = wb_valid_in && !w_coal && wb_ready_out;
    assign w_drop       = wb_valid_in && !w_coal && !wb_ready_out;
    assign w_pop        = w_draining && dmem_ack_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_state    <= ST_IDLE;
            r_overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].valid <= 1'b0;
            end
        end else begin
            if (w_coal) begin
                r_entries[w_coal_idx].data <= wb_data_in;
            end else if (w_push) begin
                r_entries[r_tail] <= '{valid: 1'b1, addr: wb_address_in, data: wb_data_in};
                r_tail            <= r_tail + 1'b1;
            end
            // Head is never the push slot here: a pop needs count>0, a push needs count<DEPTH.
            if (w_pop) begin
                r_entries[r_head].valid <= 1'b0;
                r_head                  <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                ST_IDLE:  if (r_count != '0) r_state <= ST_DRAIN;
                ST_DRAIN: if (dmem_ack_in)   r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign dmem_we_out      = w_draining;
    assign dmem_address_out = w_draining ? r_entries[r_head].addr : '0;
    assign dmem_data_out    = w_draining ? r_entries[r_head].data : '0;
    assign fwd_hit_out      = w_fwd_hit;
    assign fwd_data_out     = w_fwd_data;
    assign empty_out        = (r_count == '0) && !w_draining;
    assign overflow_out     = r_overflow;

endmodule

// File: tb/tb_l2_writeback_buffer.sv
// Randomised and directed checks of l2_writeback_buffer against a queue-based model.
module tb_l2_writeback_buffer;
    import l2_writeback_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_valid_in = 1'b0;
    logic [29:0] wb_address_in = '0;
    logic [31:0] wb_data_in = '0;
    logic        wb_ready_out;
    logic [6:0]  rd_opcode_in = '0;
    logic [29:0] rd_address_in = '0;
    logic        fwd_hit_out;
    logic [31:0] fwd_data_out;
    logic        dmem_we_out;
    logic [29:0] dmem_address_out;
    logic [31:0] dmem_data_out;
    logic        dmem_ack_in = 1'b0;
    logic        empty_out;
    logic        overflow_out;

    l2_writeback_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .wb_valid_in(wb_valid_in), .wb_address_in(wb_address_in), .wb_data_in(wb_data_in),
        .wb_ready_out(wb_ready_out),
        .rd_opcode_in(rd_opcode_in), .rd_address_in(rd_address_in),
        .fwd_hit_out(fwd_hit_out), .fwd_data_out(fwd_data_out),
        .dmem_we_out(dmem_we_out), .dmem_address_out(dmem_address_out),
        .dmem_data_out(dmem_data_out), .dmem_ack_in(dmem_ack_in),
        .empty_out(empty_out), .overflow_out(overflow_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } ment_t;

    ment_t       mq[$];
    bit          m_drain;
    bit          m_ovf;
    logic [31:0] dlog[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    logic        s_we, s_hit, s_ready, s_empty, s_ovf;
    logic [29:0] s_addr;
    logic [31:0] s_data, s_fdat;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic v, input logic [29:0] a, input logic [31:0] d,
                              input logic ack, input logic rst);
        int n;
        int j;
        if (rst) begin
            mq.delete();
            m_drain = 0;
            m_ovf   = 0;
        end else begin
            n = mq.size();
            j = -1;
            if (v) begin
                for (int i = (m_drain ? 1 : 0); i < n; i++)
                    if (mq[i].a == a) j = i;
            end
            if (v && j >= 0) mq[j].d = d;
            if (m_drain && ack) void'(mq.pop_front());
            if (v && j < 0) begin
                if (n < DEPTH) mq.push_back('{a: a, d: d});
                else m_ovf = 1;
            end
            m_drain = m_drain ? !ack : (n > 0);
        end
    endtask

    task automatic step(input logic v, input logic [29:0] a, input logic [31:0] d,
                        input logic [6:0] op, input logic [29:0] ra,
                        input logic ack, input logic rst, input bit do_chk);
        logic        e_hit;
        logic [31:0] e_fdat;
        wb_valid_in   = v;
        wb_address_in = a;
        wb_data_in    = d;
        rd_opcode_in  = op;
        rd_address_in = ra;
        dmem_ack_in   = ack;
        reset         = rst;
        @(negedge clk);
        s_we = dmem_we_out; s_addr = dmem_address_out; s_data = dmem_data_out;
        s_hit = fwd_hit_out; s_fdat = fwd_data_out; s_ready = wb_ready_out;
        s_empty = empty_out; s_ovf = overflow_out;
        if (do_chk) begin
            e_hit  = 1'b0;
            e_fdat = '0;
            if (op == OPC_LOAD) begin
                foreach (mq[i]) if (mq[i].a == ra) begin e_hit = 1'b1; e_fdat = mq[i].d; end
            end
            chk("we",    32'(s_we),    32'(m_drain));
            chk("addr",  32'(s_addr),  m_drain ? 32'(mq[0].a) : 32'd0);
            chk("data",  s_data,       m_drain ? mq[0].d : 32'd0);
            chk("hit",   32'(s_hit),   32'(e_hit));
            chk("fdat",  s_fdat,       e_fdat);
            chk("ready", 32'(s_ready), 32'(mq.size() < DEPTH));
            chk("empty", 32'(s_empty), 32'(mq.size() == 0 && !m_drain));
            chk("ovf",   32'(s_ovf),   32'(m_ovf));
        end
        if (s_we && ack && !rst) dlog.push_back(s_data);
        @(posedge clk);
        model_edge(v, a, d, ack, rst);
        #1;
    endtask

    task automatic idle(input logic ack);
        step(1'b0, '0, '0, OPC_STORE, '0, ack, 1'b0, 1'b1);
    endtask

    task automatic push(input logic [29:0] a, input logic [31:0] d, input logic ack);
        step(1'b1, a, d, OPC_STORE, '0, ack, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [29:0] addrs [6];
        logic [6:0]  op;
        int          r;
        addrs[0] = 30'h10; addrs[1] = 30'h20; addrs[2] = 30'h30;
        addrs[3] = 30'h40; addrs[4] = 30'h50; addrs[5] = 30'h60;

        step(1'b0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        chk("rst_ready", 32'(s_ready), 32'd1);
        chk("rst_empty", 32'(s_empty), 32'd1);
        chk("rst_we",    32'(s_we),    32'd0);

        // Single write held for three cycles before the ack.
        push(30'h0000100, 32'h11111111, 1'b0);
        idle(1'b0);
        idle(1'b0); idle(1'b0); idle(1'b1);
        chk("single_data", s_data, 32'h11111111);
        idle(1'b0);
        chk("single_empty", 32'(s_empty), 32'd1);

        // Same address as the head being drained becomes a new entry.
        dlog.delete();
        push(30'h10, 32'hA, 1'b0);
        push(30'h20, 32'hB, 1'b0);
        push(30'h10, 32'hC, 1'b0);
        chk("no_coal_count", 32'(mq.size()), 32'd3);
        for (int i = 0; i < 10; i++) idle(1'b1);
        chk("order_n", 32'(dlog.size()), 32'd3);
        if (dlog.size() == 3) begin
            chk("order_0", dlog[0], 32'hA);
            chk("order_1", dlog[1], 32'hB);
            chk("order_2", dlog[2], 32'hC);
        end

        // Fill and overflow with ack held low.
        dlog.delete();
        for (int i = 0; i < 4; i++) push(addrs[i], 32'h100 + 32'(i), 1'b0);
        push(30'h77, 32'hBAD, 1'b0);
        chk("full_ready", 32'(s_ready), 32'd0);
        idle(1'b0);
        chk("ovf_set", 32'(s_ovf), 32'd1);
        for (int i = 0; i < 12; i++) idle(1'b1);
        foreach (dlog[i]) chk("dropped_not_written", 32'(dlog[i] == 32'hBAD), 32'd0);
        do_reset();

        // Forwarding by opcode.
        idle(1'b0);
        push(30'h40, 32'hDEADBEEF, 1'b0);
        step(1'b0, '0, '0, OPC_LOAD, 30'h40, 1'b0, 1'b0, 1'b1);
        chk("fwd_hit",  32'(s_hit), 32'd1);
        chk("fwd_data", s_fdat, 32'hDEADBEEF);
        step(1'b0, '0, '0, OPC_STORE, 30'h40, 1'b0, 1'b0, 1'b1);
        chk("fwd_store", 32'(s_hit), 32'd0);

        // Push and pop together around count three, wrapping the pointers.
        do_reset();
        push(30'h100, 1, 1'b0); push(30'h101, 2, 1'b0); push(30'h102, 3, 1'b0);
        for (int i = 0; i < 10; i++) push(30'h200 + 30'(i), 32'h300 + 32'(i), 1'b1);

        // Reset in the middle of a drain.
        do_reset();
        push(30'h11, 5, 1'b0); push(30'h12, 6, 1'b0); idle(1'b0);
        do_reset();
        idle(1'b0);
        chk("rst_drain_we",    32'(s_we),    32'd0);
        chk("rst_drain_empty", 32'(s_empty), 32'd1);
        chk("rst_drain_ovf",   32'(s_ovf),   32'd0);

        for (int c = 0; c < 2000; c++) begin
            r  = $urandom_range(0, 99);
            op = (r < 70) ? OPC_LOAD : (r < 85) ? OPC_STORE : 7'($urandom);
            step($urandom_range(0, 99) < 45, addrs[$urandom_range(0, 5)], $urandom, op,
                 addrs[$urandom_range(0, 5)], $urandom_range(0, 99) < 40,
                 $urandom_range(0, 299) == 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
